spi_ctrl_rx: RTL

SPI_CTRL_RX -- requirements
Module: spi_ctrl_rx

---
 rtl/spi_ctrl_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_ctrl_rx.sv
// spi_ctrl_rx: SPI-fed control register file with frame validation, soft reset address and error counting
module spi_ctrl_rx #(
    parameter int NREGS = 10,
    parameter logic [6:0] RSTADDR = 7'h0F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       cs,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       word_valid,
    output logic [6:0] word_addr,
    output logic [8:0] word_data,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       active
);
    localparam int NR = NREGS > 10 ? NREGS : 10;
    localparam int AW = $clog2(NR);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t      state;
    logic [2:0]  sck_s;
    logic [2:0]  cs_s;
    logic [1:0]  mosi_s;
    logic [15:0] sr;
    logic [4:0]  cnt;
    logic [8:0]  regs [NR];
    logic        sck_rise;
    logic        cs_rise;
    logic        cs_fall;
    logic        in_range;
    logic        is_rst;
    logic        ok;

    function automatic logic [8:0] dflt(input int i);
        case (i)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4, 7:    return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            default: return 9'h000;
        endcase
    endfunction

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign cs_rise  = cs_s[1] & ~cs_s[2];
    assign cs_fall  = ~cs_s[1] & cs_s[2];
    assign in_range = int'(sr[15:9]) < NREGS;
    assign is_rst   = sr[15:9] == RSTADDR;
    assign ok       = cnt == 5'd16 && (in_range || is_rst);
    assign active   = regs[9][0];

    // Two-flop synchronizers; the third sck/cs stage exists only for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_s  <= 3'b000;
            cs_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], spi_sck};
            cs_s   <= {cs_s[1:0], cs};
            mosi_s <= {mosi_s[0], spi_mosi};
        end
    end

    // Frame FSM, register file, word/error reporting and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            word_addr  <= '0;
            word_data  <= '0;
            rd_data    <= '0;
            for (int i = 0; i < NR; i++) regs[i] <= dflt(i);
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            rd_data    <= int'(rd_addr) < NREGS ? regs[rd_addr[AW-1:0]] : 9'h000;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state <= SHIFT;
                        sr    <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sck_rise) begin
                        sr  <= {sr[14:0], mosi_s[1]};
                        cnt <= cnt == 5'd17 ? cnt : cnt + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (ok) begin
                        word_valid <= 1'b1;
                        word_addr  <= sr[15:9];
                        word_data  <= sr[8:0];
                        if (is_rst)
                            for (int i = 0; i < NR; i++) regs[i] <= dflt(i);
                        else
                            regs[sr[9 +: AW]] <= sr[8:0];
                    end else begin
                        frame_err <= 1'b1;
                        err_count <= err_count == 8'hFF ? err_count : err_count + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule
